// File: rtl/mem_stage_vec.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_vec
// Description : Memory pipeline stage with data memory and MEM/WB register.
//               Scalar accesses complete in one cycle; vector accesses are
//               split into LANES sequential word accesses while the upstream
//               pipeline is stalled.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_vec #(
  parameter int DATA_W    = 16,
  parameter int LANES     = 4,
  parameter int MEM_DEPTH = 1024,
  parameter int REG_W     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      regWriteM,
  input  logic                      memWriteM,
  input  logic                      resultSrcM,
  input  logic                      vecM,
  input  logic [DATA_W-1:0]         aluResM,
  input  logic [DATA_W*LANES-1:0]   writeDataM,
  input  logic [REG_W-1:0]          RdM,
  output logic                      stallM,
  output logic [DATA_W-1:0]         aluResW,
  output logic [DATA_W*LANES-1:0]   readDataW,
  output logic [DATA_W*LANES-1:0]   writeDataW,
  output logic [REG_W-1:0]          RdW,
  output logic                      regWriteW,
  output logic                      resultSrcW,
  output logic                      vecW
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int LW = $clog2(LANES);
  localparam int VW = DATA_W * LANES;
  localparam int BW = DATA_W * (LANES - 1);

  localparam logic [0:0]    S_IDLE    = 1'b0;
  localparam logic [0:0]    S_BUSY    = 1'b1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  // Data memory: not cleared by reset
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // Sequencer state
  logic [0:0]    state_q, state_d;
  logic [LW-1:0] lane_q,  lane_d;
  logic [BW-1:0] buf_q,   buf_d;

  // Control captured at the start of a vector op so BUSY ignores input changes
  logic             vmemwr_q, vmemwr_d;
  logic             vregw_q,  vregw_d;
  logic             vrsrc_q,  vrsrc_d;
  logic [REG_W-1:0] vrd_q,    vrd_d;

  // MEM/WB register
  logic [DATA_W-1:0] aluResW_q,    aluResW_d;
  logic [VW-1:0]     readDataW_q,  readDataW_d;
  logic [VW-1:0]     writeDataW_q, writeDataW_d;
  logic [REG_W-1:0]  RdW_q,        RdW_d;
  logic              regWriteW_q,  regWriteW_d;
  logic              resultSrcW_q, resultSrcW_d;
  logic              vecW_q,       vecW_d;

  // Memory port (lane_q is zero in IDLE, so the same adder serves both states)
  logic [AW-1:0]     idx;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] wr_word;
  logic              mem_we;

  // Address, write data and write enable of the single memory port
  always_comb begin
    idx     = aluResM[AW-1:0] + AW'(lane_q);
    rd_word = mem[idx];
    wr_word = writeDataM[int'(lane_q)*DATA_W +: DATA_W];
    mem_we  = !rst && (((state_q == S_IDLE) && memWriteM) ||
                       ((state_q == S_BUSY) && vmemwr_q));
  end

  // Memory write on the clock edge; reads in the same cycle see old data
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= wr_word;
    end
  end

  // Sequencer, stall generation and next-value of the MEM/WB register
  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    buf_d        = buf_q;
    vmemwr_d     = vmemwr_q;
    vregw_d      = vregw_q;
    vrsrc_d      = vrsrc_q;
    vrd_d        = vrd_q;
    stallM       = 1'b0;
    // Default is a bubble; overwritten when a result completes
    aluResW_d    = '0;
    readDataW_d  = '0;
    writeDataW_d = '0;
    RdW_d        = '0;
    regWriteW_d  = 1'b0;
    resultSrcW_d = 1'b0;
    vecW_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (vecM) begin
          stallM                     = 1'b1;
          buf_d[DATA_W-1:0]          = rd_word;
          vmemwr_d                   = memWriteM;
          vregw_d                    = regWriteM;
          vrsrc_d                    = resultSrcM;
          vrd_d                      = RdM;
          lane_d                     = LW'(1);
          state_d                    = S_BUSY;
        end else begin
          aluResW_d                  = aluResM;
          readDataW_d[DATA_W-1:0]    = rd_word;
          writeDataW_d               = writeDataM;
          RdW_d                      = RdM;
          regWriteW_d                = regWriteM;
          resultSrcW_d               = resultSrcM;
        end
      end
      default: begin
        if (lane_q != LAST_LANE) begin
          stallM                                = 1'b1;
          buf_d[int'(lane_q)*DATA_W +: DATA_W]  = rd_word;
          lane_d                                = lane_q + LW'(1);
        end else begin
          aluResW_d    = aluResM;
          readDataW_d  = {rd_word, buf_q};
          writeDataW_d = writeDataM;
          RdW_d        = vrd_q;
          regWriteW_d  = vregw_q;
          resultSrcW_d = vrsrc_q;
          vecW_d       = 1'b1;
          lane_d       = '0;
          state_d      = S_IDLE;
        end
      end
    endcase
  end

  // State and MEM/WB register update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lane_q       <= '0;
      buf_q        <= '0;
      vmemwr_q     <= 1'b0;
      vregw_q      <= 1'b0;
      vrsrc_q      <= 1'b0;
      vrd_q        <= '0;
      aluResW_q    <= '0;
      readDataW_q  <= '0;
      writeDataW_q <= '0;
      RdW_q        <= '0;
      regWriteW_q  <= 1'b0;
      resultSrcW_q <= 1'b0;
      vecW_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      buf_q        <= buf_d;
      vmemwr_q     <= vmemwr_d;
      vregw_q      <= vregw_d;
      vrsrc_q      <= vrsrc_d;
      vrd_q        <= vrd_d;
      aluResW_q    <= aluResW_d;
      readDataW_q  <= readDataW_d;
      writeDataW_q <= writeDataW_d;
      RdW_q        <= RdW_d;
      regWriteW_q  <= regWriteW_d;
      resultSrcW_q <= resultSrcW_d;
      vecW_q       <= vecW_d;
    end
  end

  assign aluResW    = aluResW_q;
  assign readDataW  = readDataW_q;
  assign writeDataW = writeDataW_q;
  assign RdW        = RdW_q;
  assign regWriteW  = regWriteW_q;
  assign resultSrcW = resultSrcW_q;
  assign vecW       = vecW_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_vec.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_vec
// Description : Self-checking bench for mem_stage_vec with a word-level
//               memory model and randomized scalar/vector traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_vec;

  localparam int DW = 16;
  localparam int L  = 4;
  localparam int D  = 1024;
  localparam int RW = 4;
  localparam int VW = DW * L;

  logic          clk = 1'b0;
  logic          rst;
  logic          regWriteM, memWriteM, resultSrcM, vecM;
  logic [DW-1:0] aluResM;
  logic [VW-1:0] writeDataM;
  logic [RW-1:0] RdM;
  logic          stallM;
  logic [DW-1:0] aluResW;
  logic [VW-1:0] readDataW, writeDataW;
  logic [RW-1:0] RdW;
  logic          regWriteW, resultSrcW, vecW;

  mem_stage_vec #(.DATA_W(DW), .LANES(L), .MEM_DEPTH(D), .REG_W(RW)) dut (
    .clk(clk), .rst(rst),
    .regWriteM(regWriteM), .memWriteM(memWriteM), .resultSrcM(resultSrcM),
    .vecM(vecM), .aluResM(aluResM), .writeDataM(writeDataM), .RdM(RdM),
    .stallM(stallM), .aluResW(aluResW), .readDataW(readDataW),
    .writeDataW(writeDataW), .RdW(RdW), .regWriteW(regWriteW),
    .resultSrcW(resultSrcW), .vecW(vecW)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Reference memory: word contents plus a flag saying the content is known
  logic [DW-1:0] mdl  [D];
  bit            mval [D];

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    regWriteM  = 1'b0; memWriteM = 1'b0; resultSrcM = 1'b0; vecM = 1'b0;
    aluResM    = '0;   writeDataM = '0;  RdM = '0;
  endtask

  // Present one operation, follow it through the stall and check the result.
  task automatic apply(input bit vec, input bit we, input logic [DW-1:0] addr,
                       input logic [VW-1:0] wd, input logic [RW-1:0] rd,
                       input bit rw, input bit rs, output int t_res);
    logic [VW-1:0] exp_rd;
    bit            known;
    int            nl, idx, t0, n;
    nl     = vec ? L : 1;
    exp_rd = '0;
    known  = 1'b1;
    for (int k = 0; k < nl; k++) begin
      idx = (int'(addr) + k) % D;
      if (!mval[idx]) known = 1'b0;
      exp_rd[k*DW +: DW] = mdl[idx];
      if (we) begin
        mdl[idx]  = wd[k*DW +: DW];
        mval[idx] = 1'b1;
      end
    end
    @(negedge clk);
    vecM = vec; memWriteM = we; aluResM = addr; writeDataM = wd;
    RdM = rd; regWriteM = rw; resultSrcM = rs;
    t0 = cyc;
    #1;
    n = 0;
    while (stallM === 1'b1 && n < L + 2) begin
      @(posedge clk); #1;
      check("bubble", {RdW, regWriteW, vecW}, '0);
      n++;
    end
    check("stall_cycles", n, vec ? L - 1 : 0);
    @(posedge clk); #1;
    check("latency", cyc - t0, nl);
    check("aluResW", aluResW, addr);
    check("writeDataW", writeDataW, wd);
    check("RdW", RdW, rd);
    check("ctrlW", {regWriteW, resultSrcW, vecW}, {rw, rs, vec});
    if (known) check("readDataW", readDataW, exp_rd);
    t_res = cyc;
  endtask

  int t1, t2;
  logic [VW-1:0] v;

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    check("rst_stall", stallM, 0);
    check("rst_aluResW", aluResW, 0);
    check("rst_readDataW", readDataW, 0);
    check("rst_writeDataW", writeDataW, 0);
    check("rst_ctrl", {RdW, regWriteW, resultSrcW, vecW}, 0);

    // Give every word a known value
    for (int i = 0; i < D; i++)
      apply(1'b0, 1'b1, DW'(i), VW'($urandom), 4'd0, 1'b0, 1'b0, t1);

    // Scalar store then load
    apply(1'b0, 1'b1, 16'h0010, 64'h0000_0000_0000_BEEF, 4'd1, 1'b0, 1'b0, t1);
    apply(1'b0, 1'b0, 16'h0010, 64'h0, 4'd5, 1'b1, 1'b1, t1);

    // Vector store / load
    apply(1'b1, 1'b1, 16'h0020, 64'h4444_3333_2222_1111, 4'd0, 1'b0, 1'b0, t1);
    apply(1'b1, 1'b0, 16'h0020, 64'h0, 4'd6, 1'b1, 1'b0, t1);
    apply(1'b0, 1'b0, 16'h0023, 64'h0, 4'd2, 1'b1, 1'b0, t1);

    // Wrap-around at top of memory
    v = {$urandom, $urandom};
    apply(1'b1, 1'b1, 16'h03FE, v, 4'd0, 1'b0, 1'b0, t1);
    apply(1'b1, 1'b0, 16'h03FE, 64'h0, 4'd9, 1'b1, 1'b0, t1);
    apply(1'b0, 1'b0, 16'h0000, 64'h0, 4'd3, 1'b1, 1'b0, t1);
    apply(1'b0, 1'b0, 16'h0001, 64'h0, 4'd4, 1'b1, 1'b0, t1);

    // Reset during lane 2 of a vector store
    v = 64'hD4D4_C3C3_B2B2_A1A1;
    @(negedge clk);
    vecM = 1'b1; memWriteM = 1'b1; aluResM = 16'h0040; writeDataM = v;
    RdM = 4'd2; regWriteM = 1'b0; resultSrcM = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    check("midrst_stall", stallM, 0);
    check("midrst_aluResW", aluResW, 0);
    check("midrst_readDataW", readDataW, 0);
    check("midrst_writeDataW", writeDataW, 0);
    check("midrst_ctrl", {RdW, regWriteW, resultSrcW, vecW}, 0);
    mdl[16'h40] = 16'hA1A1;
    mdl[16'h41] = 16'hB2B2;
    mval[16'h42] = 1'b0;
    apply(1'b0, 1'b0, 16'h0041, 64'h0, 4'd7, 1'b1, 1'b0, t1);
    apply(1'b0, 1'b0, 16'h0040, 64'h0, 4'd7, 1'b1, 1'b0, t1);
    apply(1'b0, 1'b0, 16'h0043, 64'h0, 4'd7, 1'b1, 1'b0, t1);

    // Back-to-back vector load and scalar load
    apply(1'b1, 1'b0, 16'h0020, 64'h0, 4'd3, 1'b1, 1'b0, t1);
    apply(1'b0, 1'b0, 16'h0010, 64'h0, 4'd7, 1'b1, 1'b0, t2);
    check("b2b_gap", t2 - t1, 1);

    // Same-cycle read/write returns old data
    apply(1'b0, 1'b1, 16'h0055, 64'h0000_0000_0000_AAAA, 4'd0, 1'b0, 1'b0, t1);
    apply(1'b0, 1'b1, 16'h0055, 64'h0000_0000_0000_1234, 4'd0, 1'b0, 1'b0, t1);
    apply(1'b0, 1'b0, 16'h0055, 64'h0, 4'd8, 1'b1, 1'b0, t1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      apply(1'($urandom), 1'($urandom), 16'($urandom), {$urandom, $urandom},
            4'($urandom), 1'($urandom), 1'($urandom), t1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage_vec.md
Name: mem_stage_vec

Overview:
Parametrised memory pipeline stage for the vector encryption CPU. It holds the data memory and the MEM/WB pipeline register, and adds multi-lane vector load/store. A vector access is split into LANES sequential word accesses by a small sequencer, which stalls the upstream pipeline until the access completes. Scalar accesses behave exactly as in the current single-cycle memory stage. The block sits between the execute/MEM register and the writeback stage.

Parameters:
DATA_W, 16, width of one data word / lane
LANES, 4, words per vector access (must be >= 2)
MEM_DEPTH, 1024, data memory depth in words (power of two); index width AW = log2(MEM_DEPTH)
REG_W, 4, destination register index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
regWriteM  in  1  register-write enable from MEM
memWriteM  in  1  memory-write enable
resultSrcM  in  1  writeback select (passed through)
vecM  in  1  1 = vector access of LANES words, 0 = scalar
aluResM  in  DATA_W  effective address (scalar) or base address (vector)
writeDataM  in  DATA_W*LANES  store data; lane k = bits [k*DATA_W +: DATA_W]; scalar uses lane 0
RdM  in  REG_W  destination register
stallM  out  1  hold request to IF/ID/EX/MEM registers
aluResW  out  DATA_W  registered aluResM
readDataW  out  DATA_W*LANES  registered load data
writeDataW  out  DATA_W*LANES  registered writeDataM
RdW  out  REG_W  registered RdM
regWriteW  out  1  registered regWriteM (0 on bubbles)
resultSrcW  out  1  registered resultSrcM
vecW  out  1  registered vecM

Behaviour:
- Memory: MEM_DEPTH x DATA_W array with combinational read and write on the clk edge. The word index is the address taken modulo MEM_DEPTH (low AW bits of the address). A read and a write to the same word in the same cycle return the old data. The memory is not cleared by rst.
- FSM states: IDLE and BUSY. A lane counter `lane` has width ceil(log2(LANES)).
- IDLE, vecM=0 (scalar):
  - Access index aluResM.
  - If memWriteM=1, write writeDataM lane 0.
  - The W register captures all M fields on the next edge. readDataW lane 0 = mem[aluResM]; upper lanes = 0.
  - stallM=0. Latency is 1 cycle.
- IDLE, vecM=1:
  - Access lane 0 at aluResM.
  - stallM=1 (combinational) and a read buffer captures lane 0.
  - At the next edge: state->BUSY, lane->1, and the W register loads a bubble (regWriteW=0, RdW=0, vecW=0, data fields 0).
- BUSY:
  - Access index (aluResM + lane) mod MEM_DEPTH. The address wraps at the top of memory.
  - The write, if memWriteM=1, uses lane `lane` of writeDataM.
  - While lane < LANES-1: stallM=1, buffer[lane] captures the read, lane increments, and W loads a bubble.
  - On lane = LANES-1: stallM=0. At the edge, the W register captures the M fields with readDataW = buffer lanes 0..LANES-2 plus the current read in lane LANES-1; state->IDLE, lane->0.
- Vector timing: stallM is high for exactly LANES-1 cycles and the result appears LANES cycles after presentation.
- Upstream holds all M inputs stable while stallM=1. The block samples vecM/memWriteM only in IDLE. Input changes during BUSY are not sampled, except address and data, which must be held stable.
- Reset (sampled on the clk edge, takes priority over everything):
  - state=IDLE, lane=0, buffer=0, and all W outputs = 0.
  - stallM=0 in the cycle after reset.
  - A vector access in flight is abandoned. Lane writes already performed remain in memory; no further lanes are written.
- A scalar op presented while BUSY cannot occur, because upstream is stalled.

Test Plan:
- Scalar store then load: store 0xBEEF at address 0x0010; next cycle load 0x0010 -> readDataW lane0=0xBEEF, upper lanes 0, stallM never high, regWriteW=1 one cycle after the load.
- Vector store/load: vector store {0x4444,0x3333,0x2222,0x1111} (lane3..0) at base 0x0020 -> stallM high 3 cycles, mem[0x20..0x23]=0x1111..0x4444. Vector load from 0x0020 -> readDataW = same 64-bit value 4 cycles after presentation, with bubbles (regWriteW=0) on the 3 intervening W cycles.
- Wrap-around: MEM_DEPTH=1024, vector store base 0x03FE -> lanes written at indices 1022, 1023, 0, 1; a vector load at 0x03FE returns identical data.
- Reset mid-vector: assert rst during lane 2 of a vector store to 0x0040 -> lanes 0..1 written, lane 3 index 0x0043 unchanged. Next cycle stallM=0 and all W outputs 0; a following scalar load of 0x0041 returns lane1 data.
- Back-to-back: vector load immediately followed by a scalar load held behind the stall -> the scalar result appears exactly 1 cycle after the vector result, with correct RdW for each.
- Same-cycle read/write: scalar store of 0x1234 to a word holding 0xAAAA -> that cycle's read value is 0xAAAA, and a later load returns 0x1234.
